// File: rtl/serial_deframer_if.sv
// -----------------------------------------------------------------------------
// serial_deframer_if
// Bundles the serial input stream and the word-output handshake of the
// serial deframer.
//   bit_i        serial data bit (MSB of each word first)
//   bit_valid_i  qualifies bit_i
//   data_o       deserialised word held in the output register
//   valid_o      data_o holds an unconsumed word
//   ready_i      consumer accepts data_o when valid_o && ready_i
//   locked_o     deframer is collecting payload
//   frame_done_o one-cycle pulse after the last word of a frame
//   overflow_o   one-cycle pulse after a completed word was dropped
// Modports:
//   slave  - the deframer itself (consumes bits, produces words)
//   master - the environment (produces bits, consumes words)
// -----------------------------------------------------------------------------
interface serial_deframer_if #(
    parameter int DATA_W = 8
);
    logic              bit_i;
    logic              bit_valid_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              locked_o;
    logic              frame_done_o;
    logic              overflow_o;

    modport slave (
        input  bit_i,
        input  bit_valid_i,
        input  ready_i,
        output data_o,
        output valid_o,
        output locked_o,
        output frame_done_o,
        output overflow_o
    );

    modport master (
        output bit_i,
        output bit_valid_i,
        output ready_i,
        input  data_o,
        input  valid_o,
        input  locked_o,
        input  frame_done_o,
        input  overflow_o
    );
endinterface

// File: rtl/serial_deframer.sv
// -----------------------------------------------------------------------------
// serial_deframer
// Hunts for a sync word in a qualified serial bit stream, then deserialises
// NUM_WORDS payload words of DATA_W bits each, MSB first. Completed words go
// to a one-entry valid/ready output register; a word that completes while
// that register is full and not being drained is dropped and flagged.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_deframer_if.slave (bit stream in, word handshake out,
//        locked / frame_done / overflow status)
//
// DATA_W and SYNC_W are expected to be at least 2; NUM_WORDS at least 1.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_deframer #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                NUM_WORDS    = 4
) (
    input  logic            clk,
    input  logic            rst,
    serial_deframer_if.slave bus
);

    // State encoding kept as plain constants.
    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // Fill counter must be able to hold the value SYNC_W itself.
    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

    // Framing state
    logic [0:0]        state_r;
    logic              locked_r;
    logic [SYNC_W-1:0] hunt_r;
    logic [FILL_W-1:0] fill_r;
    logic [DATA_W-1:0] word_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [WORD_W-1:0] word_cnt_r;

    // Output register and status pulses
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              frame_done_r;
    logic              overflow_r;

    // Combinational helpers
    logic [SYNC_W-1:0] hunt_next_s;
    logic [FILL_W-1:0] fill_next_s;
    logic [DATA_W-1:0] word_next_s;
    logic              sample_hunt_s;
    logic              sample_collect_s;
    logic              sync_hit_s;
    logic              word_done_s;
    logic              frame_end_s;
    logic              can_load_s;

    // Next-value and event decode for the current bit.
    always_comb begin
        hunt_next_s      = {hunt_r[SYNC_W-2:0], bus.bit_i};
        word_next_s      = {word_r[DATA_W-2:0], bus.bit_i};

        if (fill_r == FILL_FULL) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FILL_W'(1'b1);
        end

        sample_hunt_s    = bus.bit_valid_i && (state_r == ST_HUNT);
        sample_collect_s = bus.bit_valid_i && (state_r == ST_COLLECT);

        // The fill check includes the bit being sampled now, so a pattern
        // can only match once SYNC_W genuine bits have been seen.
        sync_hit_s  = sample_hunt_s && (fill_next_s == FILL_FULL) &&
                      (hunt_next_s == SYNC_PATTERN);
        word_done_s = sample_collect_s && (bit_cnt_r == BIT_LAST);
        frame_end_s = word_done_s && (word_cnt_r == WORD_LAST);

        // The output slot is free if empty or being emptied this very edge.
        can_load_s  = !valid_r || bus.ready_i;
    end

    // Hunt / collect state machine with its shift registers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_HUNT;
            locked_r   <= 1'b0;
            hunt_r     <= '0;
            fill_r     <= '0;
            word_r     <= '0;
            bit_cnt_r  <= '0;
            word_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (sync_hit_s) begin
                        state_r    <= ST_COLLECT;
                        locked_r   <= 1'b1;
                        hunt_r     <= '0;
                        fill_r     <= '0;
                        word_r     <= '0;
                        bit_cnt_r  <= '0;
                        word_cnt_r <= '0;
                    end else if (sample_hunt_s) begin
                        hunt_r <= hunt_next_s;
                        fill_r <= fill_next_s;
                    end else begin
                        hunt_r <= hunt_r;
                        fill_r <= fill_r;
                    end
                end
                ST_COLLECT: begin
                    if (sample_collect_s) begin
                        word_r <= word_next_s;
                        if (frame_end_s) begin
                            // Back to hunting; a complete fresh sync word is
                            // required before the next frame.
                            state_r    <= ST_HUNT;
                            locked_r   <= 1'b0;
                            hunt_r     <= '0;
                            fill_r     <= '0;
                            bit_cnt_r  <= '0;
                            word_cnt_r <= '0;
                        end else if (word_done_s) begin
                            // Dropped words still count towards the frame.
                            bit_cnt_r  <= '0;
                            word_cnt_r <= word_cnt_r + WORD_W'(1'b1);
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + BIT_W'(1'b1);
                        end
                    end else begin
                        word_r <= word_r;
                    end
                end
                default: begin
                    state_r    <= ST_HUNT;
                    locked_r   <= 1'b0;
                    hunt_r     <= '0;
                    fill_r     <= '0;
                    bit_cnt_r  <= '0;
                    word_cnt_r <= '0;
                end
            endcase
        end
    end

    // One-entry output register plus frame_done / overflow pulses; drains
    // regardless of framing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= '0;
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
            overflow_r   <= word_done_s && !can_load_s;
            if (word_done_s && can_load_s) begin
                data_r  <= word_next_s;
                valid_r <= 1'b1;
            end else if (valid_r && bus.ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign bus.data_o       = data_r;
    assign bus.valid_o      = valid_r;
    assign bus.locked_o     = locked_r;
    assign bus.frame_done_o = frame_done_r;
    assign bus.overflow_o   = overflow_r;

endmodule

// File: tb/tb_serial_deframer.sv
// -----------------------------------------------------------------------------
// tb_serial_deframer
// Drives directed and random bit streams into serial_deframer. A reference
// model in the stimulus process predicts, per clock edge, which words reach
// the output register, when overflow / frame_done pulse and when lock
// changes; a negedge monitor compares the DUT against those expectations.
// -----------------------------------------------------------------------------
module tb_serial_deframer;

    localparam int SYNC = 8'hA5;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    serial_deframer_if #(.DATA_W(8)) bus ();

    serial_deframer #(
        .DATA_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .NUM_WORDS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Expectation queues
    ev_t exp_words[$];   // cyc = cycle the word first becomes visible
    ev_t exp_ovf[$];
    ev_t exp_fd[$];
    ev_t exp_lock[$];

    // Reference model state
    bit m_locked = 1'b0;
    int m_hist = 0;
    int m_fill = 0;
    int m_word = 0;
    int m_nbits = 0;
    int m_nwords = 0;
    bit m_full = 1'b0;

    // Stimulus knobs
    int gap_pct = 0;
    int rst_pct = 0;
    int rdy_mode = 1;   // 0 never, 1 always, 2 random
    bit alt = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Predict what the coming clock edge does, from the stream rules.
    task automatic model_edge(input bit b, input bit bv, input bit rdy, input bit rs);
        int  e = cyc + 1;
        bit  old_lock = m_locked;
        bit  loaded = 1'b0;
        bit  accept;
        if (rs) begin
            m_locked = 1'b0; m_hist = 0; m_fill = 0;
            m_word = 0; m_nbits = 0; m_nwords = 0; m_full = 1'b0;
            exp_words.delete();
        end else begin
            accept = m_full && rdy;
            if (bv && !m_locked) begin
                m_hist = ((m_hist << 1) | int'(b)) & 255;
                if (m_fill < 8) m_fill++;
                if (m_fill == 8 && m_hist == SYNC) begin
                    m_locked = 1'b1; m_hist = 0; m_fill = 0;
                    m_word = 0; m_nbits = 0; m_nwords = 0;
                end
            end else if (bv) begin
                m_word = (m_word * 2 + int'(b)) & 255;
                m_nbits++;
                if (m_nbits == 8) begin
                    m_nbits = 0;
                    m_nwords++;
                    if (!m_full || rdy) begin
                        exp_words.push_back('{e, m_word});
                        m_full = 1'b1;
                        loaded = 1'b1;
                    end else begin
                        exp_ovf.push_back('{e, m_word});
                    end
                    if (m_nwords == 4) begin
                        exp_fd.push_back('{e, 1});
                        m_locked = 1'b0; m_hist = 0; m_fill = 0; m_nwords = 0;
                    end
                    m_word = 0;
                end
            end
            if (accept && !loaded) m_full = 1'b0;
        end
        if (m_locked != old_lock) exp_lock.push_back('{e, int'(m_locked)});
    endtask

    task automatic step(input bit b, input bit bv, input bit rdy, input bit rs);
        bus.bit_i       = b;
        bus.bit_valid_i = bv;
        bus.ready_i     = rdy;
        rst             = rs;
        model_edge(b, bv, rdy, rs);
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_rdy();
        if (rdy_mode == 0) return 1'b0;
        else if (rdy_mode == 1) return 1'b1;
        else return 1'($urandom_range(1));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, pick_rdy(), 1'b0);
    endtask

    task automatic send_bit(input bit b);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1'($urandom_range(1)), 1'b0, pick_rdy(), 1'b0);
        if (rst_pct > 0 && $urandom_range(99) < rst_pct) step(1'b0, 1'b0, pick_rdy(), 1'b1);
        step(b, 1'b1, pick_rdy(), 1'b0);
        if (alt) step(1'b0, 1'b0, pick_rdy(), 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
        send_byte(8'hA5);
        send_byte(w0); send_byte(w1); send_byte(w2); send_byte(w3);
    endtask

    // Monitor: samples mid-cycle and pops expectations as the DUT presents them.
    bit rst_prev = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_locked = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if (rst_prev) begin
            cmp("rst_data", int'(bus.data_o), 0);
            cmp("rst_valid", int'(bus.valid_o), 0);
            cmp("rst_locked", int'(bus.locked_o), 0);
            cmp("rst_frame_done", int'(bus.frame_done_o), 0);
            cmp("rst_overflow", int'(bus.overflow_o), 0);
        end
        if (bus.locked_o !== prev_locked) begin
            if (exp_lock.size() == 0) cmp("lock_unexpected", int'(bus.locked_o), int'(prev_locked));
            else begin
                ev = exp_lock.pop_front();
                cmp("lock_cycle", cyc, ev.cyc);
                cmp("lock_value", int'(bus.locked_o), ev.val);
            end
        end
        if (bus.overflow_o === 1'b1) begin
            if (exp_ovf.size() == 0) cmp("overflow_unexpected", 1, 0);
            else begin
                ev = exp_ovf.pop_front();
                cmp("overflow_cycle", cyc, ev.cyc);
            end
        end
        if (bus.frame_done_o === 1'b1) begin
            if (exp_fd.size() == 0) cmp("frame_done_unexpected", 1, 0);
            else begin
                ev = exp_fd.pop_front();
                cmp("frame_done_cycle", cyc, ev.cyc);
            end
        end
        if (!rst && bus.valid_o === 1'b1 && !prev_valid) begin
            if (exp_words.size() == 0) cmp("valid_unexpected", 1, 0);
            else cmp("valid_latency", cyc, exp_words[0].cyc);
        end
        if (!rst && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            if (exp_words.size() == 0) cmp("word_unexpected", int'(bus.data_o), -1);
            else begin
                ev = exp_words.pop_front();
                cmp("word_data", int'(bus.data_o), ev.val);
            end
        end
        rst_prev    = rst;
        prev_valid  = bus.valid_o;
        prev_locked = bus.locked_o;
    end

    initial begin
        // 1: reset, then one clean frame at full rate
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        idle(4);

        // 2: consumer stalled for the whole payload
        send_byte(8'hA5);
        rdy_mode = 0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(3);
        rdy_mode = 1;
        idle(3);

        // 3: bit_valid toggling every cycle
        alt = 1'b1;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        alt = 1'b0;
        idle(3);

        // 4: near-miss sync patterns before the real one
        send_byte(8'hA4); send_byte(8'h5A);
        send_frame(8'h5C, 8'hC3, 8'h00, 8'hFF);
        idle(3);

        // 5: reset in the middle of word 2
        send_byte(8'hA5); send_byte(8'h66);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h77, 8'h88, 8'h99, 8'hAA);
        idle(3);

        // 6: output drained on the same edge a new word completes
        send_byte(8'hA5);
        rdy_mode = 0;
        send_byte(8'h12);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'h34 >> i) & 1));
        rdy_mode = 1;
        send_bit(1'b0);   // LSB of 0x34
        send_byte(8'h56); send_byte(8'h78);
        idle(4);

        // Random frames with junk, gaps, back-pressure and occasional resets
        for (int f = 0; f < 24; f++) begin
            gap_pct  = $urandom_range(40);
            rdy_mode = (f % 3 == 0) ? 1 : 2;
            rst_pct  = (f % 5 == 4) ? 1 : 0;
            for (int j = 0; j < int'($urandom_range(12)); j++) send_bit(1'($urandom_range(1)));
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        gap_pct = 0; rst_pct = 0; rdy_mode = 1;
        idle(20);

        cmp("words_pending", exp_words.size(), 0);
        cmp("overflow_pending", exp_ovf.size(), 0);
        cmp("frame_done_pending", exp_fd.size(), 0);
        cmp("lock_pending", exp_lock.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
